// File: rtl/mips_pkg.sv
// Shared opcodes, ALU operations and stage bundles
// for the 5-stage MIPS-I integer pipeline.
package mips_pkg;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_SYS  = 6'h0c;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
        ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_B
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic        is_r;
        logic        is_i;
        logic        is_j;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  dest;
        logic        wr;
        logic        ld;
        logic        st;
        logic        ret;
        logic        use_imm;
        logic        shv;
        logic [4:0]  shamt;
        alu_op_e     op;
        logic [31:0] imm;
        logic [31:0] a;
        logic [31:0] b;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic        wr;
        logic        ld;
        logic        st;
        logic        ret;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] sd;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic        wr;
        logic        ret;
        logic [4:0]  dest;
        logic [31:0] data;
    } mem_wb_t;

endpackage

// File: rtl/mips_if.sv
// Register-file access bundle: two read ports
// and one write port.
interface mips_if;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;

    modport master (
        output ra1, ra2, we, wa, wd,
        input  rd1, rd2
    );
    modport slave (
        input  ra1, ra2, we, wa, wd,
        output rd1, rd2
    );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file, r0 hardwired to zero, with
// write-through bypass so issue sees the WB result.
module mips_regfile
    import mips_pkg::*;
(
    input logic   clk,
    input logic   reset,
    mips_if.slave rf
);

    logic [31:0] reg_file [0:31];

    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_file[0] <= '0;
        end else if (rf.we && rf.wa != 5'd0) begin
            reg_file[rf.wa] <= rf.wd;
        end
    end

    assign rf.rd1 = (rf.ra1 == 5'd0) ? '0 :
                    (rf.we && rf.wa == rf.ra1) ? rf.wd :
                    reg_file[rf.ra1];
    assign rf.rd2 = (rf.ra2 == 5'd0) ? '0 :
                    (rf.we && rf.wa == rf.ra2) ? rf.wd :
                    reg_file[rf.ra2];

endmodule

// File: rtl/mips_pipe_top.sv
// 5-stage in-order MIPS-I pipeline: fetch, issue,
// execute, memory, write-back. No stalls, no flushes.
module mips_pipe_top
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 4096,
    parameter int          DMEM_WORDS = 4096
) (
    input logic clk,
    input logic reset
);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] curr_pc_pc_reg_fetch;
    logic [31:0] instr_pc_reg_fetch;

    if_id_t  if_id;
    id_ex_t  id_ex, id_nx;
    ex_mem_t ex_mem, ex_nx;
    mem_wb_t mem_wb, mem_nx;

    logic        is_r_type_iss_ex;
    logic        is_i_type_iss_ex;
    logic        is_j_type_iss_ex;
    logic [4:0]  rs_iss_ex;
    logic [4:0]  rt_iss_ex;
    logic [4:0]  rd_iss_ex;
    logic        reg_wr_wb_ret;
    logic [31:0] wr_data_rf_wb_ret;
    logic        instr_retired;

    mips_if rf ();

    mips_regfile R1 (
        .clk   (clk),
        .reset (reset),
        .rf    (rf)
    );

    assign curr_pc_pc_reg_fetch = pc;
    assign instr_pc_reg_fetch   = imem[pc[13:2]];

    logic [31:0] iw;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] imm_s;
    logic        br_taken;
    logic [31:0] br_target;

    assign iw     = if_id.instr;
    assign opc    = iw[31:26];
    assign fn     = iw[5:0];
    assign imm_s  = {{16{iw[15]}}, iw[15:0]};
    assign rf.ra1 = iw[25:21];
    assign rf.ra2 = iw[20:16];

    always_comb begin
        id_nx         = '0;
        id_nx.valid   = if_id.valid;
        id_nx.rs      = iw[25:21];
        id_nx.rt      = iw[20:16];
        id_nx.rd      = iw[15:11];
        id_nx.shamt   = iw[10:6];
        id_nx.op      = ALU_ADD;
        id_nx.imm     = imm_s;
        id_nx.a       = rf.rd1;
        id_nx.b       = rf.rd2;
        case (opc)
            OP_R: begin
                id_nx.is_r = 1'b1;
                id_nx.ret  = 1'b1;
                id_nx.wr   = 1'b1;
                id_nx.dest = iw[15:11];
                case (fn)
                    F_SLL:  id_nx.op = ALU_SLL;
                    F_SRL:  id_nx.op = ALU_SRL;
                    F_SRA:  id_nx.op = ALU_SRA;
                    F_SLLV: begin
                        id_nx.op  = ALU_SLL;
                        id_nx.shv = 1'b1;
                    end
                    F_SRLV: begin
                        id_nx.op  = ALU_SRL;
                        id_nx.shv = 1'b1;
                    end
                    F_SRAV: begin
                        id_nx.op  = ALU_SRA;
                        id_nx.shv = 1'b1;
                    end
                    F_ADD, F_ADDU: id_nx.op = ALU_ADD;
                    F_SUB, F_SUBU: id_nx.op = ALU_SUB;
                    F_AND:  id_nx.op = ALU_AND;
                    F_OR:   id_nx.op = ALU_OR;
                    F_XOR:  id_nx.op = ALU_XOR;
                    F_NOR:  id_nx.op = ALU_NOR;
                    F_SLT:  id_nx.op = ALU_SLT;
                    F_SLTU: id_nx.op = ALU_SLTU;
                    F_JR, F_SYS: id_nx.wr = 1'b0;
                    default: begin
                        id_nx.wr  = 1'b0;
                        id_nx.ret = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE: begin
                id_nx.is_i    = 1'b1;
                id_nx.ret     = 1'b1;
                id_nx.use_imm = 1'b1;
                id_nx.dest    = iw[20:16];
                id_nx.wr      = !(opc == OP_SW ||
                                  opc == OP_BEQ ||
                                  opc == OP_BNE);
            end
            OP_J, OP_JAL: id_nx.is_j = 1'b1;
            default: ;
        endcase
        case (opc)
            OP_SLTI:  id_nx.op = ALU_SLT;
            OP_SLTIU: id_nx.op = ALU_SLTU;
            OP_ANDI: begin
                id_nx.op  = ALU_AND;
                id_nx.imm = {16'h0, iw[15:0]};
            end
            OP_ORI: begin
                id_nx.op  = ALU_OR;
                id_nx.imm = {16'h0, iw[15:0]};
            end
            OP_XORI: begin
                id_nx.op  = ALU_XOR;
                id_nx.imm = {16'h0, iw[15:0]};
            end
            OP_LUI: begin
                id_nx.op  = ALU_B;
                id_nx.imm = {iw[15:0], 16'h0};
            end
            OP_LW: id_nx.ld = 1'b1;
            OP_SW: id_nx.st = 1'b1;
            default: ;
        endcase
        id_nx.wr = id_nx.wr && (id_nx.dest != 5'd0);
    end

    // The instruction behind a branch is already fetched: that is the delay slot.
    always_comb begin
        br_taken  = 1'b0;
        br_target = if_id.pc + 32'd4 + (imm_s << 2);
        if (if_id.valid) begin
            case (opc)
                OP_BEQ: br_taken = (rf.rd1 == rf.rd2);
                OP_BNE: br_taken = (rf.rd1 != rf.rd2);
                OP_R: begin
                    if (fn == F_JR) begin
                        br_taken  = 1'b1;
                        br_target = rf.rd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign next_pc = br_taken ? br_target : pc + 32'd4;

    assign is_r_type_iss_ex = id_ex.is_r;
    assign is_i_type_iss_ex = id_ex.is_i;
    assign is_j_type_iss_ex = id_ex.is_j;
    assign rs_iss_ex        = id_ex.rs;
    assign rt_iss_ex        = id_ex.rt;
    assign rd_iss_ex        = id_ex.rd;

    logic [31:0] fa, fb, opb, res;
    logic [4:0]  sh;

    // MEM overrides WB (youngest wins); a load in MEM has no data yet.
    always_comb begin
        fa = id_ex.a;
        fb = id_ex.b;
        if (mem_wb.valid && mem_wb.wr && mem_wb.dest == id_ex.rs)
            fa = mem_wb.data;
        if (mem_wb.valid && mem_wb.wr && mem_wb.dest == id_ex.rt)
            fb = mem_wb.data;
        if (ex_mem.valid && ex_mem.wr && !ex_mem.ld &&
            ex_mem.dest == id_ex.rs)
            fa = ex_mem.res;
        if (ex_mem.valid && ex_mem.wr && !ex_mem.ld &&
            ex_mem.dest == id_ex.rt)
            fb = ex_mem.res;
        opb = id_ex.use_imm ? id_ex.imm : fb;
        sh  = id_ex.shv ? fa[4:0] : id_ex.shamt;
        case (id_ex.op)
            ALU_ADD:  res = fa + opb;
            ALU_SUB:  res = fa - opb;
            ALU_AND:  res = fa & opb;
            ALU_OR:   res = fa | opb;
            ALU_XOR:  res = fa ^ opb;
            ALU_NOR:  res = ~(fa | opb);
            ALU_SLT:  res = {31'h0, $signed(fa) < $signed(opb)};
            ALU_SLTU: res = {31'h0, fa < opb};
            ALU_SLL:  res = fb << sh;
            ALU_SRL:  res = fb >> sh;
            ALU_SRA:  res = $unsigned($signed(fb) >>> sh);
            ALU_B:    res = opb;
            default:  res = fa + opb;
        endcase
    end

    always_comb begin
        ex_nx       = '0;
        ex_nx.valid = id_ex.valid;
        ex_nx.wr    = id_ex.wr;
        ex_nx.ld    = id_ex.ld;
        ex_nx.st    = id_ex.st;
        ex_nx.ret   = id_ex.ret;
        ex_nx.dest  = id_ex.dest;
        ex_nx.res   = res;
        ex_nx.sd    = fb;
    end

    always_comb begin
        mem_nx       = '0;
        mem_nx.valid = ex_mem.valid;
        mem_nx.wr    = ex_mem.wr;
        mem_nx.ret   = ex_mem.ret;
        mem_nx.dest  = ex_mem.dest;
        mem_nx.data  = ex_mem.ld ? dmem[ex_mem.res[13:2]]
                                 : ex_mem.res;
    end

    always_ff @(posedge clk) begin
        if (reset && ex_mem.valid && ex_mem.st)
            dmem[ex_mem.res[13:2]] <= ex_mem.sd;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc     <= RESET_PC;
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            pc          <= next_pc;
            if_id.pc    <= pc;
            if_id.instr <= instr_pc_reg_fetch;
            if_id.valid <= 1'b1;
            id_ex       <= id_nx;
            ex_mem      <= ex_nx;
            mem_wb      <= mem_nx;
        end
    end

    assign instr_retired     = mem_wb.valid && mem_wb.ret;
    assign reg_wr_wb_ret     = mem_wb.valid && mem_wb.wr;
    assign wr_data_rf_wb_ret = mem_wb.data;
    assign rf.we             = reg_wr_wb_ret;
    assign rf.wa             = mem_wb.dest;
    assign rf.wd             = mem_wb.data;

endmodule

// File: tb/tb_mips_pipe_top.sv
// Directed program with a per-retirement expectation
// table plus final architectural state checks.
module tb_mips_pipe_top;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mips_pipe_top dut (
        .clk   (clk),
        .reset (reset)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] data;
    } ret_vec_t;

    ret_vec_t    tbl [19];
    logic [31:0] prog [20];
    int passed = 0;
    int total = 0;
    int ridx = 0;
    logic early = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    initial begin
        prog = '{
            32'h24030100, // addiu r3,r0,0x100
            32'h24010005, // addiu r1,r0,5
            32'h24220003, // addiu r2,r1,3
            32'hAC020000, // sw r2,0(r0)
            32'h8C030000, // lw r3,0(r0)
            32'h00633821, // addu r7,r3,r3 (load slot)
            32'h00632021, // addu r4,r3,r3
            32'h10000002, // beq r0,r0,+2
            32'h24050001, // addiu r5,r0,1 (delay slot)
            32'h24050063, // addiu r5,r0,99 (skipped)
            32'h24000007, // addiu r0,r0,7
            32'h2401FFFF, // addiu r1,r0,-1
            32'h24020001, // addiu r2,r0,1
            32'h0022302A, // slt r6,r1,r2
            32'h0022402B, // sltu r8,r1,r2
            32'h00015702, // srl r10,r1,28
            32'h14000005, // bne r0,r0,+5
            32'h3C0B1234, // lui r11,0x1234
            32'h2402000A, // addiu r2,r0,10
            32'h0000000C  // syscall
        };
        tbl = '{
            '{"r3_init", 1'b1, 32'h100},
            '{"r1_5", 1'b1, 32'd5},
            '{"r2_fwd", 1'b1, 32'd8},
            '{"sw", 1'b0, 32'h0},
            '{"lw", 1'b1, 32'd8},
            '{"ld_slot", 1'b1, 32'h200},
            '{"after_ld", 1'b1, 32'd16},
            '{"beq", 1'b0, 32'h0},
            '{"br_slot", 1'b1, 32'd1},
            '{"r0_wr", 1'b0, 32'h0},
            '{"r1_m1", 1'b1, 32'hFFFFFFFF},
            '{"r2_1", 1'b1, 32'd1},
            '{"slt", 1'b1, 32'd1},
            '{"sltu", 1'b1, 32'd0},
            '{"srl", 1'b1, 32'hF},
            '{"bne", 1'b0, 32'h0},
            '{"lui", 1'b1, 32'h12340000},
            '{"r2_10", 1'b1, 32'd10},
            '{"syscall", 1'b0, 32'h0}
        };
        for (int i = 0; i < 4096; i++) dut.imem[i] = 32'h0;
        for (int i = 0; i < 20; i++) dut.imem[i] = prog[i];

        repeat (5) begin
            @(negedge clk);
            if (dut.instr_retired) early = 1'b1;
        end
        chk("no_retire_in_reset", {31'h0, early}, 32'h0);
        reset = 1'b1;
        #1;
        chk("fetch_pc0", dut.curr_pc_pc_reg_fetch, 32'h0);
        chk("fetch_instr0", dut.instr_pc_reg_fetch, prog[0]);

        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 8) chk("pc_slot", dut.curr_pc_pc_reg_fetch, 32'd32);
            if (c == 9) chk("pc_target", dut.curr_pc_pc_reg_fetch, 32'd40);
            if (dut.instr_retired) begin
                if (ridx < 19) begin
                    chk({tbl[ridx].name, "_cycle"}, c, ridx + 4);
                    chk({tbl[ridx].name, "_wr"},
                        {31'h0, dut.reg_wr_wb_ret}, {31'h0, tbl[ridx].wr});
                    if (tbl[ridx].wr)
                        chk({tbl[ridx].name, "_data"},
                            dut.wr_data_rf_wb_ret, tbl[ridx].data);
                    if (ridx == 18)
                        chk("syscall_r2", dut.R1.reg_file[2], 32'd10);
                end
                ridx++;
            end
        end
        chk("retire_count", {31'h0, ridx >= 19}, 32'h1);

        chk("r0_zero", dut.R1.reg_file[0], 32'h0);
        chk("r4_final", dut.R1.reg_file[4], 32'd16);
        chk("r5_final", dut.R1.reg_file[5], 32'd1);
        chk("r6_final", dut.R1.reg_file[6], 32'd1);
        chk("r7_final", dut.R1.reg_file[7], 32'h200);
        chk("r8_final", dut.R1.reg_file[8], 32'd0);
        chk("r10_final", dut.R1.reg_file[10], 32'hF);
        chk("r11_final", dut.R1.reg_file[11], 32'h12340000);
        chk("dmem0", dut.dmem[0], 32'd8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
